// File: rtl/md_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states and
// the operation type latched at issue.
package md_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } md_op_e;

    function automatic md_op_e md_op_decode(input logic is_mult, input logic is_unsigned);
        return md_op_e'({~is_mult, is_unsigned});
    endfunction

endpackage

// File: rtl/md_sequencer_engine.sv
// Iterative radix-2 datapath: shift-add multiply and restoring divide on
// magnitudes, with the sign/div-by-zero fix presented combinationally.
module md_engine
    import md_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             fix_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             dbz_o
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, orig_a_q;
    logic             is_mult_q, neg_res_q, neg_rem_q, dbz_q;

    md_op_e           op_e;
    logic             signed_op, mult_op, a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   add_sum, sub_diff;

    always_comb begin
        op_e      = md_op_e'(op_i);
        signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
        mult_op   = (op_e == OP_MULT) || (op_e == OP_MULTU);
        a_neg     = signed_op & op_a_i[WIDTH-1];
        b_neg     = signed_op & op_b_i[WIDTH-1];
        // The most-negative value negates to itself, which read unsigned is 2^(WIDTH-1).
        abs_a     = a_neg ? -op_a_i : op_a_i;
        abs_b     = b_neg ? -op_b_i : op_b_i;
    end

    always_comb begin
        add_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        sub_diff = acc_q[W2-1:WIDTH-1] - {1'b0, mcand_q};
        if (is_mult_q) begin
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end else if (!sub_diff[WIDTH]) begin
            acc_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {acc_q[W2-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            orig_a_q  <= '0;
            is_mult_q <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else if (load_i) begin
            // Multiply: {product_hi, multiplier}. Divide: {remainder, dividend/quotient}.
            acc_q     <= mult_op ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
            mcand_q   <= mult_op ? abs_a : abs_b;
            orig_a_q  <= op_a_i;
            is_mult_q <= mult_op;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg & ~mult_op;
            dbz_q     <= ~mult_op & (op_b_i == '0);
        end else if (step_i) begin
            acc_q <= acc_d;
        end else if (fix_i) begin
            // Working state is scrubbed on the same edge the result is retired.
            acc_q     <= '0;
            mcand_q   <= '0;
            orig_a_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end
    end

    always_comb begin
        res_hi_o = '0;
        res_lo_o = '0;
        if (dbz_q) begin
            res_hi_o = orig_a_q;
            res_lo_o = '1;
        end else if (is_mult_q) begin
            {res_hi_o, res_lo_o} = neg_res_q ? -acc_q : acc_q;
        end else begin
            res_lo_o = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            res_hi_o = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
        end
    end

    assign dbz_o = dbz_q;

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: issue FSM, iteration counter, Hi/Lo registers,
// decode stall and the MFHI/MFLO read mux.
//
// state | meaning
// IDLE  | waiting for an issue; Hi/Lo readable without stall
// CALC  | one engine iteration per cycle, cnt counts down to 0
// FIX   | sign/div-by-zero correction visible, done pulse, Hi/Lo written on exit
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             md_start_i,
    input  logic             md_is_mult_i,
    input  logic             md_is_unsigned_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             lhr_ren_i,
    input  logic             lhr_is_hi_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             div_by_zero_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, dbz_q;

    logic             eng_load, eng_step, eng_fix, eng_dbz;
    logic [WIDTH-1:0] eng_hi, eng_lo;

    assign eng_load = (state_q == ST_IDLE) & md_start_i;
    assign eng_step = (state_q == ST_CALC);
    assign eng_fix  = (state_q == ST_FIX);

    md_engine #(.WIDTH(WIDTH)) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (eng_load),
        .step_i   (eng_step),
        .fix_i    (eng_fix),
        .op_i     (md_op_decode(md_is_mult_i, md_is_unsigned_i)),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .res_hi_o (eng_hi),
        .res_lo_o (eng_lo),
        .dbz_o    (eng_dbz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (md_start_i) begin
                        state_q <= ST_CALC;
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        busy_q  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_FIX;
                        done_q  <= 1'b1;
                        dbz_q   <= eng_dbz;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    hi_q    <= eng_hi;
                    lo_q    <= eng_lo;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign stall_o       = busy_q & (md_start_i | lhr_ren_i);
    assign rdata_o       = lhr_is_hi_i ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed and randomized bench for md_sequencer against an arithmetic model
// of Hi/Lo results, busy length, stall and reset behaviour.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_start, md_is_mult, md_is_unsigned;
    logic [31:0] op_a, op_b;
    logic        lhr_ren, lhr_is_hi;
    logic [31:0] rdata;
    logic        busy, stall, done, div_by_zero;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cur_hi   = 32'h0;
    logic [31:0] cur_lo   = 32'h0;

    always #5 clk = ~clk;

    md_sequencer #(.WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .md_start_i       (md_start),
        .md_is_mult_i     (md_is_mult),
        .md_is_unsigned_i (md_is_unsigned),
        .op_a_i           (op_a),
        .op_b_i           (op_b),
        .lhr_ren_i        (lhr_ren),
        .lhr_is_hi_i      (lhr_is_hi),
        .rdata_o          (rdata),
        .busy_o           (busy),
        .stall_o          (stall),
        .done_o           (done),
        .div_by_zero_o    (div_by_zero)
    );

    // op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU. Returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int                sa, sb, q, r;
        longint            lp;
        longint unsigned   up;
        sa = a;
        sb = b;
        case (op)
            2'd0: begin lp = longint'(sa) * longint'(sb); return lp; end
            2'd1: begin up = {32'h0, a} * {32'h0, b}; return up; end
            2'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start       = 1'b1;
        md_is_mult     = ~op[1];
        md_is_unsigned = op[0];
        op_a           = a;
        op_b           = b;
    endtask

    // Called #1 after the accepting edge with md_start already dropped.
    task automatic finish_op(input string tag, input logic [63:0] exp, input bit exp_dbz);
        int busy_n = 0;
        int done_n = 0;
        int dbz_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_n++;
            if (done) done_n++;
            if (div_by_zero !== (done & exp_dbz)) dbz_bad++;
        end
        chk({tag, "/busy_cycles"}, 64'(busy_n), 64'd33);
        chk({tag, "/done_pulses"}, 64'(done_n), 64'd1);
        chk({tag, "/dbz_flag"}, 64'(dbz_bad), 64'd0);
        lhr_is_hi = 1'b1;
        #1 chk({tag, "/hi"}, 64'(rdata), 64'(exp[63:32]));
        lhr_is_hi = 1'b0;
        #1 chk({tag, "/lo"}, 64'(rdata), 64'(exp[31:0]));
        cur_hi = exp[63:32];
        cur_lo = exp[31:0];
    endtask

    // Issue from IDLE together with an MFHI: the read must see the old Hi, no stall.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        exp = model(op, a, b);
        @(negedge clk);
        drive_op(op, a, b);
        lhr_ren   = 1'b1;
        lhr_is_hi = 1'b1;
        #1 chk({tag, "/old_hi"}, 64'(rdata), 64'(cur_hi));
        chk({tag, "/idle_stall"}, 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        md_start = 1'b0;
        lhr_ren  = 1'b0;
        finish_op(tag, exp, op[1] && (b == 32'h0));
    endtask

    initial begin
        logic [63:0] exp2, exp3;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          n, bad;

        rst_n = 1'b0;
        md_start = 1'b0; md_is_mult = 1'b0; md_is_unsigned = 1'b0;
        op_a = 32'h0; op_b = 32'h0; lhr_ren = 1'b1; lhr_is_hi = 1'b1;
        #3;
        chk("reset/busy", 64'(busy), 64'd0);
        chk("reset/stall", 64'(stall), 64'd0);
        chk("reset/done", 64'(done), 64'd0);
        chk("reset/dbz", 64'(div_by_zero), 64'd0);
        chk("reset/rdata", 64'(rdata), 64'd0);
        lhr_ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mult_m3x7", 2'd0, 32'hFFFF_FFFD, 32'd7);
        do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("div_m7d2", 2'd2, 32'hFFFF_FFF9, 32'd2);
        do_op("divu_7d2", 2'd3, 32'd7, 32'd2);
        do_op("div_minneg", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("div_by0", 2'd2, 32'h1234_5678, 32'h0);
        do_op("divu_by0", 2'd3, 32'h8765_4321, 32'h0);
        do_op("mult_minneg", 2'd0, 32'h8000_0000, 32'h8000_0000);

        // MFHI raised 5 cycles after issue stalls until busy falls.
        exp2 = model(2'd3, 32'd1000, 32'd7);
        @(negedge clk);
        drive_op(2'd3, 32'd1000, 32'd7);
        @(posedge clk);
        #1 md_start = 1'b0;
        repeat (4) @(negedge clk);
        lhr_ren = 1'b1; lhr_is_hi = 1'b1;
        n = 0; bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (stall !== 1'b1) bad++;
        end
        chk("mfhi_wait/busy_rest", 64'(n), 64'd29);
        chk("mfhi_wait/stall_held", 64'(bad), 64'd0);
        chk("mfhi_wait/idle_stall", 64'(stall), 64'd0);
        chk("mfhi_wait/rdata", 64'(rdata), 64'(exp2[63:32]));
        lhr_ren = 1'b0;
        cur_hi = exp2[63:32]; cur_lo = exp2[31:0];

        // A second issue held through busy is taken only in the first IDLE cycle.
        exp2 = model(2'd0, 32'd12345, 32'hFFFF_FF00);
        exp3 = model(2'd2, 32'hDEAD_BEEF, 32'd13);
        @(negedge clk);
        drive_op(2'd0, 32'd12345, 32'hFFFF_FF00);
        @(posedge clk);
        #1 drive_op(2'd2, 32'hDEAD_BEEF, 32'd13);
        lhr_is_hi = 1'b0;
        n = 0; bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (stall !== 1'b1) bad++;
        end
        chk("held_start/busy1", 64'(n), 64'd33);
        chk("held_start/stall_held", 64'(bad), 64'd0);
        chk("held_start/idle_stall", 64'(stall), 64'd0);
        chk("held_start/first_lo", 64'(rdata), 64'(exp2[31:0]));
        @(posedge clk);
        #1 md_start = 1'b0;
        finish_op("held_start/second", exp3, 1'b0);

        // Reset mid-CALC at cnt = 20 drops everything.
        @(negedge clk);
        drive_op(2'd0, 32'h0001_2345, 32'h0000_6789);
        @(posedge clk);
        #1 md_start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        lhr_ren = 1'b1; lhr_is_hi = 1'b1;
        #1;
        chk("midreset/busy", 64'(busy), 64'd0);
        chk("midreset/stall", 64'(stall), 64'd0);
        chk("midreset/hi", 64'(rdata), 64'd0);
        lhr_is_hi = 1'b0;
        #1 chk("midreset/lo", 64'(rdata), 64'd0);
        lhr_ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cur_hi = 32'h0; cur_lo = 32'h0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("midreset/no_done", 64'(bad), 64'd0);
        do_op("after_reset_2x3", 2'd0, 32'd2, 32'd3);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the non-pipelined MIPS core. It accepts MULT, MULTU, DIV and DIVU issues from decode and runs an iterative radix-2 engine for WIDTH cycles. It owns the Hi/Lo registers and serves MFHI/MFLO reads. It raises `stall` to freeze the PC and register-file write whenever a new mult/div or a Hi/Lo read arrives while a previous operation is still running.

## Interface
- `WIDTH`, default 32: operand width. Hi and Lo are each WIDTH bits wide.
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `md_start`  in  1  issue strobe: decode has a MULT/MULTU/DIV/DIVU (`lhr_wen` from ControlUnit).
- `md_is_mult`  in  1  1 = multiply, 0 = divide.
- `md_is_unsigned`  in  1  1 = MULTU/DIVU.
- `op_a`  in  WIDTH  rs value (multiplicand / dividend).
- `op_b`  in  WIDTH  rt value (multiplier / divisor).
- `lhr_ren`  in  1  MFHI/MFLO in decode.
- `lhr_is_hi`  in  1  1 = MFHI, 0 = MFLO.
- `rdata`  out  WIDTH  `lhr_is_hi ? hi : lo`, combinational.
- `busy`  out  1  1 while state ≠ IDLE.
- `stall`  out  1  `busy & (md_start | lhr_ren)`, combinational.
- `done`  out  1  1-cycle pulse in FIX state.
- `div_by_zero`  out  1  1-cycle pulse coincident with `done` for DIV/DIVU when `op_b` = 0.

## Operation
- **FSM states:** IDLE, CALC, FIX.
- **IDLE:** `md_start` = 1 is accepted on the edge.
  - Latch the operation type.
  - Latch `|op_a|` and `|op_b|` (raw values if unsigned).
  - Latch the operand signs, and the div-by-zero flag if the divisor is 0.
  - Load `cnt` = WIDTH−1 and go to CALC.
- **CALC:** one iteration per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - `cnt` decrements each cycle; at `cnt` = 0 go to FIX.
- **FIX:** `done` = 1, and the sign correction is applied. Hi/Lo are written on the exit edge, then the FSM returns to IDLE.
  - Signed multiply: negate the 2·WIDTH product if the operand signs differ. Hi = upper half, Lo = lower half.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign. Lo = quotient, Hi = remainder.
  - Divide by zero (either signedness) overrides the result: Lo = all ones, Hi = original `op_a`, and `div_by_zero` = 1.
  - Most-negative ÷ −1 wraps: Lo = 0x80000000, Hi = 0. Not flagged.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH per half. The absolute value of the most-negative number is taken as an unsigned 2^(WIDTH−1).
- **`md_start` while busy:** not accepted. `stall` holds decode, so the same instruction re-presents `md_start` and is accepted in the first IDLE cycle.
- **`lhr_ren` while busy:** `stall` = 1 and `rdata` is don't-care. In the first IDLE cycle `rdata` shows the new Hi/Lo and `stall` = 0.
- **`lhr_ren` while IDLE:** `rdata` returns the current Hi/Lo with no stall.
- **`md_start` and `lhr_ren` in the same cycle:** cannot come from a single instruction. If both are seen in IDLE, the read returns the old Hi/Lo and the start is accepted.
- **Reset (asynchronous, any state including mid-CALC):**
  - FSM → IDLE, `cnt` = 0, Hi = Lo = 0, accumulators cleared.
  - `busy`, `stall`, `done` and `div_by_zero` all = 0; `rdata` = 0.
  - Any in-flight result is discarded.

## Timing
- Start accepted at edge E0.
- CALC occupies the cycles after edges E0..E(WIDTH−1).
- FIX is the cycle after edge E(WIDTH); Hi/Lo are written at edge E(WIDTH+1).
- `busy` is high for WIDTH+1 cycles: 33 for WIDTH = 32.
- A dependent MFHI/MFLO in the cycle right after issue stalls 33 cycles.
- `done` and `div_by_zero` are registered-state decodes, glitch-free. `stall` and `rdata` are combinational.

## Structure
- **Shared package / def include:**
  - State encoding localparams (IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2).
  - MD operation type encoding (MULT, MULTU, DIV, DIVU).
  - Mult/div funct codes stay in the existing instruction definitions.
- **Sub-module `md_engine`:** the iterative datapath (accumulator, shift/add/subtract, sign fix), driven by `step`, `load` and `fix` strobes.
- **Top level:** `md_sequencer` holds the FSM, `cnt`, Hi/Lo, and the stall and read mux.

## Test plan
- MULT −3 × 7 → Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB. `busy` high exactly 33 cycles; `done` is a single-cycle pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → Hi = 0xFFFFFFFE, Lo = 0x00000001.
- DIV −7 / 2 → Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. DIVU 7 / 2 → Lo = 3, Hi = 1. DIV 0x80000000 / −1 → Lo = 0x80000000, Hi = 0.
- DIV 0x12345678 / 0 → Hi = 0x12345678, Lo = 0xFFFFFFFF, with `div_by_zero` and `done` high in the same cycle.
- MFHI raised 5 cycles after issue → `stall` = 1 until `busy` falls. First IDLE cycle has `rdata` = new Hi and `stall` = 0. A second `md_start` held during `busy` is accepted only after IDLE and then runs the full 33 cycles.
- `rst_n` pulled low during CALC (`cnt` = 20) → `busy` = 0 immediately, Hi = Lo = 0, no `done`. A following MULT 2 × 3 gives Lo = 6 after 33 cycles.
